// File: rtl/aes_model_pack.sv
// aes_model_pack: shared AES model constants and types, plus the key/sync loader frame width and state type.
package aes_model_pack;
   localparam int BLOCK_SIZE = 128;
   localparam int KEY_SYNC_W = 2 * BLOCK_SIZE;
   typedef logic [7:0] byte_table [0:255];
   typedef enum logic {COLLECT, SEND} loader_state_t;
endpackage

// File: rtl/dvr_if.sv
// dvr_if: data/valid/ready handshake channel; a transfer occurs when valid and rdy are both high.
interface dvr_if #(parameter int W = 256);
   logic [W-1:0] data;
   logic         valid;
   logic         rdy;
   modport master (output data, output valid, input rdy);
   modport slave  (input data, input valid, output rdy);
endinterface

// File: rtl/key_and_sync_word_packer.sv
// key_and_sync_word_packer: places config words into the key/sync assembly register and flags short/long frames.
module key_and_sync_word_packer
   import aes_model_pack::*;
#(parameter int WORD_W = 32) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_W-1:0]     word,
   input  logic                  accept,
   input  logic                  last,
   output logic [KEY_SYNC_W-1:0] frame_next,
   output logic                  frame_complete,
   output logic                  frame_err
);
   localparam int NUM_WORDS = KEY_SYNC_W / WORD_W;
   localparam int CW = $clog2(NUM_WORDS);
   logic [CW-1:0]         word_cnt;
   logic [KEY_SYNC_W-1:0] asm_q;
   logic                  at_end;
   assign at_end = word_cnt == CW'(NUM_WORDS - 1);
   assign frame_complete = accept && last && at_end;
   // Short frame (last too early) or long frame (no last on the final slot).
   assign frame_err = accept && (last != at_end);
   always_comb begin
      frame_next = asm_q;
      frame_next[word_cnt*WORD_W +: WORD_W] = word;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt <= '0;
         asm_q    <= '0;
      end else if (accept) begin
         asm_q    <= frame_next;
         word_cnt <= (last || at_end) ? '0 : word_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/key_and_sync_loader.sv
// key_and_sync_loader: gathers word-serial key/sync config into a 256-bit frame for the AES core
// and tracks sync-overlapse events so software knows a re-key is pending.
module key_and_sync_loader
   import aes_model_pack::*;
#(parameter int WORD_W = 32) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_vld,
   input  logic              cfg_last,
   output logic              cfg_rdy,
   dvr_if.master             key_and_sync_out,
   input  logic              sync_overlapse_irq,
   output logic              load_done,
   output logic              frame_err,
   output logic              rekey_pending,
   output logic [15:0]       frames_sent
);
   loader_state_t         state_q, state_d;
   logic [KEY_SYNC_W-1:0] frame_next, data_q;
   logic                  frame_complete, pack_err, valid_q, handshake, irq_q, irq_rise_q;
   assign cfg_rdy = state_q == COLLECT;
   assign handshake = state_q == SEND && key_and_sync_out.rdy;
   assign key_and_sync_out.data = data_q;
   assign key_and_sync_out.valid = valid_q;
   key_and_sync_word_packer #(.WORD_W(WORD_W)) u_packer (
      .clk            (clk),
      .rst            (rst),
      .word           (cfg_word),
      .accept         (cfg_vld && cfg_rdy),
      .last           (cfg_last),
      .frame_next     (frame_next),
      .frame_complete (frame_complete),
      .frame_err      (pack_err)
   );
   always_comb begin
      state_d = (state_q == COLLECT) ? (frame_complete ? SEND : COLLECT) : (handshake ? COLLECT : SEND);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= COLLECT;
         data_q        <= '0;
         valid_q       <= 1'b0;
         load_done     <= 1'b0;
         frame_err     <= 1'b0;
         rekey_pending <= 1'b0;
         frames_sent   <= '0;
         irq_q         <= 1'b0;
         irq_rise_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         data_q        <= frame_complete ? frame_next : data_q;
         valid_q       <= state_d == SEND;
         load_done     <= handshake;
         frame_err     <= pack_err;
         frames_sent   <= frames_sent + {15'd0, handshake};
         irq_q         <= sync_overlapse_irq;
         irq_rise_q    <= sync_overlapse_irq && !irq_q;
         // A new overlapse landing on the delivery edge must survive the clear.
         rekey_pending <= irq_rise_q || (rekey_pending && !handshake);
      end
   end
endmodule

// File: tb/tb_key_and_sync_loader.sv
// tb_key_and_sync_loader: directed tests of the key/sync loader at WORD_W=32 and WORD_W=64.
module tb_key_and_sync_loader;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  cfg_word = '0;
   logic         cfg_vld = 1'b0, cfg_last = 1'b0, irq = 1'b0;
   logic         cfg_rdy, load_done, frame_err, rekey;
   logic [15:0]  frames_sent;
   logic [63:0]  w_word = '0;
   logic         w_vld = 1'b0, w_last = 1'b0;
   logic         w_rdy, w_done, w_err, w_rekey;
   logic [15:0]  w_sent;
   logic [255:0] exp;
   int           n_cmp = 0, n_bad = 0;

   dvr_if #(.W(256)) ks ();
   dvr_if #(.W(256)) ks_w ();

   key_and_sync_loader #(.WORD_W(32)) dut (
      .clk (clk), .rst (rst), .cfg_word (cfg_word), .cfg_vld (cfg_vld), .cfg_last (cfg_last),
      .cfg_rdy (cfg_rdy), .key_and_sync_out (ks), .sync_overlapse_irq (irq), .load_done (load_done),
      .frame_err (frame_err), .rekey_pending (rekey), .frames_sent (frames_sent)
   );

   key_and_sync_loader #(.WORD_W(64)) dut_w (
      .clk (clk), .rst (rst), .cfg_word (w_word), .cfg_vld (w_vld), .cfg_last (w_last),
      .cfg_rdy (w_rdy), .key_and_sync_out (ks_w), .sync_overlapse_irq (1'b0), .load_done (w_done),
      .frame_err (w_err), .rekey_pending (w_rekey), .frames_sent (w_sent)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_word(input logic [31:0] w, input logic l);
      cfg_vld = 1'b1;
      cfg_word = w;
      cfg_last = l;
      tick();
      cfg_vld = 1'b0;
      cfg_last = 1'b0;
   endtask

   task automatic test_reset();
      ks.rdy = 1'b1;
      ks_w.rdy = 1'b1;
      #3;
      n_cmp++;
      if ({ks.valid, cfg_rdy, load_done, frame_err, rekey, frames_sent} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b rdy=%b ld=%b fe=%b rk=%b fs=%0d, want 0 1 0 0 0 0",
                  ks.valid, cfg_rdy, load_done, frame_err, rekey, frames_sent);
      end
      n_cmp++;
      if (ks.data !== 256'd0) begin
         n_bad++;
         $display("FAIL reset_data: got %h want 0", ks.data);
      end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_nominal();
      for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'(i);
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (cfg_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL nominal_rdy_collect: word %0d cfg_rdy=%b want 1", i, cfg_rdy);
         end
         drive_word(32'(i), i == 7);
      end
      n_cmp++;
      if ({ks.valid, cfg_rdy, load_done} !== 3'b100 || ks.data[31:0] !== 32'd0 || ks.data[255:224] !== 32'd7) begin
         n_bad++;
         $display("FAIL nominal_valid: got v=%b rdy=%b ld=%b lo=%h hi=%h, want 1 0 0 0 7",
                  ks.valid, cfg_rdy, load_done, ks.data[31:0], ks.data[255:224]);
      end
      n_cmp++;
      if (ks.data !== exp) begin
         n_bad++;
         $display("FAIL nominal_data: got %h want %h", ks.data, exp);
      end
      tick();
      n_cmp++;
      if ({ks.valid, cfg_rdy, load_done, frame_err, frames_sent} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'd1}) begin
         n_bad++;
         $display("FAIL nominal_handshake: got v=%b rdy=%b ld=%b fe=%b fs=%0d, want 0 1 1 0 1",
                  ks.valid, cfg_rdy, load_done, frame_err, frames_sent);
      end
      tick();
      n_cmp++;
      if ({load_done, ks.data == exp} !== 2'b01) begin
         n_bad++;
         $display("FAIL nominal_after: got ld=%b data_held=%b want 0 1", load_done, ks.data == exp);
      end
   endtask

   task automatic test_backpressure();
      ks.rdy = 1'b0;
      for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      for (int i = 0; i < 8; i++) drive_word(32'h1000_0000 + 32'(i), i == 7);
      cfg_vld = 1'b1;
      cfg_word = 32'hDEAD_BEEF;
      cfg_last = 1'b1;
      for (int c = 0; c < 20; c++) begin
         n_cmp++;
         if ({ks.valid, cfg_rdy, load_done, frame_err} !== 4'b1000 || ks.data !== exp) begin
            n_bad++;
            $display("FAIL backpressure_hold: cycle %0d v=%b rdy=%b ld=%b fe=%b data=%h want 1 0 0 0 %h",
                     c, ks.valid, cfg_rdy, load_done, frame_err, ks.data, exp);
         end
         tick();
      end
      cfg_vld = 1'b0;
      cfg_last = 1'b0;
      ks.rdy = 1'b1;
      tick();
      n_cmp++;
      if ({ks.valid, load_done, frames_sent} !== {1'b0, 1'b1, 16'd2}) begin
         n_bad++;
         $display("FAIL backpressure_release: got v=%b ld=%b fs=%0d want 0 1 2", ks.valid, load_done, frames_sent);
      end
      tick();
      n_cmp++;
      if ({ks.valid, load_done, frames_sent} !== {1'b0, 1'b0, 16'd2}) begin
         n_bad++;
         $display("FAIL backpressure_single: got v=%b ld=%b fs=%0d want 0 0 2", ks.valid, load_done, frames_sent);
      end
   endtask

   task automatic test_short_frame();
      for (int i = 0; i < 4; i++) drive_word(32'h2000_0000 + 32'(i), i == 3);
      n_cmp++;
      if ({frame_err, ks.valid, cfg_rdy, load_done} !== 4'b1010) begin
         n_bad++;
         $display("FAIL short_err: got fe=%b v=%b rdy=%b ld=%b want 1 0 1 0", frame_err, ks.valid, cfg_rdy, load_done);
      end
      for (int i = 0; i < 8; i++) drive_word(32'hA5A5_A5A5, i == 7);
      n_cmp++;
      if ({ks.valid, frame_err} !== 2'b10 || ks.data !== {8{32'hA5A5_A5A5}}) begin
         n_bad++;
         $display("FAIL short_recover: got v=%b fe=%b data=%h want 1 0 all a5", ks.valid, frame_err, ks.data);
      end
      tick();
      n_cmp++;
      if ({load_done, frames_sent} !== {1'b1, 16'd3}) begin
         n_bad++;
         $display("FAIL short_deliver: got ld=%b fs=%0d want 1 3", load_done, frames_sent);
      end
   endtask

   task automatic test_long_frame();
      for (int i = 0; i < 8; i++) begin
         drive_word(32'h3000_0000 + 32'(i), 1'b0);
         n_cmp++;
         if (frame_err !== (i == 7) || ks.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL long_err: word %0d fe=%b v=%b want %b 0", i, frame_err, ks.valid, i == 7);
         end
      end
      for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'h4000_0000 + 32'(i);
      for (int i = 0; i < 8; i++) drive_word(32'h4000_0000 + 32'(i), i == 7);
      n_cmp++;
      if ({ks.valid, frame_err} !== 2'b10 || ks.data !== exp) begin
         n_bad++;
         $display("FAIL long_recover: got v=%b fe=%b data=%h want 1 0 %h", ks.valid, frame_err, ks.data, exp);
      end
      tick();
      n_cmp++;
      if ({load_done, frames_sent} !== {1'b1, 16'd4}) begin
         n_bad++;
         $display("FAIL long_deliver: got ld=%b fs=%0d want 1 4", load_done, frames_sent);
      end
   endtask

   task automatic test_rekey();
      irq = 1'b1;
      tick();
      n_cmp++;
      if (rekey !== 1'b0) begin
         n_bad++;
         $display("FAIL rekey_latency1: got %b want 0", rekey);
      end
      tick();
      n_cmp++;
      if (rekey !== 1'b1) begin
         n_bad++;
         $display("FAIL rekey_set: got %b want 1", rekey);
      end
      for (int c = 0; c < 3; c++) tick();
      n_cmp++;
      if (rekey !== 1'b1) begin
         n_bad++;
         $display("FAIL rekey_sticky: got %b want 1", rekey);
      end
      for (int i = 0; i < 8; i++) drive_word(32'h5000_0000 + 32'(i), i == 7);
      tick();
      n_cmp++;
      if ({load_done, rekey} !== 2'b10) begin
         n_bad++;
         $display("FAIL rekey_clear: got ld=%b rk=%b want 1 0", load_done, rekey);
      end
      tick();
      tick();
      n_cmp++;
      if (rekey !== 1'b0) begin
         n_bad++;
         $display("FAIL rekey_level_no_reset: got %b want 0", rekey);
      end
      irq = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 7; i++) drive_word(32'h6000_0000 + 32'(i), 1'b0);
      irq = 1'b1;
      drive_word(32'h6000_0007, 1'b1);
      n_cmp++;
      if ({ks.valid, rekey} !== 2'b10) begin
         n_bad++;
         $display("FAIL rekey_pre_collide: got v=%b rk=%b want 1 0", ks.valid, rekey);
      end
      tick();
      n_cmp++;
      if ({load_done, rekey} !== 2'b11) begin
         n_bad++;
         $display("FAIL rekey_set_wins: got ld=%b rk=%b want 1 1", load_done, rekey);
      end
      tick();
      n_cmp++;
      if (rekey !== 1'b1) begin
         n_bad++;
         $display("FAIL rekey_set_wins_hold: got %b want 1", rekey);
      end
      irq = 1'b0;
   endtask

   task automatic test_reset_mid_send();
      ks.rdy = 1'b0;
      for (int i = 0; i < 8; i++) drive_word(32'h7000_0000 + 32'(i), i == 7);
      n_cmp++;
      if (ks.valid !== 1'b1) begin
         n_bad++;
         $display("FAIL midsend_setup: valid=%b want 1", ks.valid);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({ks.valid, cfg_rdy, load_done, frame_err, rekey, frames_sent} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}
          || ks.data !== 256'd0) begin
         n_bad++;
         $display("FAIL midsend_async_reset: v=%b rdy=%b ld=%b fe=%b rk=%b fs=%0d data=%h want 0 1 0 0 0 0 0",
                  ks.valid, cfg_rdy, load_done, frame_err, rekey, frames_sent, ks.data);
      end
      tick();
      rst = 1'b1;
      ks.rdy = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
      for (int i = 0; i < 8; i++) drive_word(32'hC0DE_0000 + 32'(i), i == 7);
      n_cmp++;
      if (ks.valid !== 1'b1 || ks.data !== exp) begin
         n_bad++;
         $display("FAIL midsend_fresh: v=%b data=%h want 1 %h", ks.valid, ks.data, exp);
      end
      tick();
      n_cmp++;
      if ({load_done, frames_sent} !== {1'b1, 16'd1}) begin
         n_bad++;
         $display("FAIL midsend_deliver: ld=%b fs=%0d want 1 1", load_done, frames_sent);
      end
   endtask

   task automatic test_wide();
      for (int i = 0; i < 4; i++) exp[i*64 +: 64] = 64'(i);
      for (int i = 0; i < 4; i++) begin
         w_vld = 1'b1;
         w_word = 64'(i);
         w_last = i == 3;
         tick();
      end
      w_vld = 1'b0;
      w_last = 1'b0;
      n_cmp++;
      if ({ks_w.valid, w_rdy, w_done} !== 3'b100 || ks_w.data[63:0] !== 64'd0 || ks_w.data[255:192] !== 64'd3
          || ks_w.data !== exp) begin
         n_bad++;
         $display("FAIL wide_valid: v=%b rdy=%b ld=%b data=%h want 1 0 0 %h", ks_w.valid, w_rdy, w_done, ks_w.data, exp);
      end
      tick();
      n_cmp++;
      if ({ks_w.valid, w_rdy, w_done, w_err, w_sent} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'd1}) begin
         n_bad++;
         $display("FAIL wide_handshake: v=%b rdy=%b ld=%b fe=%b fs=%0d want 0 1 1 0 1",
                  ks_w.valid, w_rdy, w_done, w_err, w_sent);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_short_frame();
      test_long_frame();
      test_rekey();
      test_reset_mid_send();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
